// File: rtl/cache_fill_fsm.sv
// Cache-line fill controller: on a miss, stalls the core, streams eight word reads
// for the aligned block, steers returning words into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        word_offset,
  output logic              write_tag_array,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [3:0] REQ_LAST = 4'(WORDS_PER_BLOCK);
  localparam logic [2:0] RSP_LAST = 3'(WORDS_PER_BLOCK - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        req_cnt_q, req_cnt_d;
  logic [2:0]        rsp_cnt_q, rsp_cnt_d;
  logic              req_pending;

  assign req_pending = (req_cnt_q != REQ_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Request and response counters advance independently; only the eighth
  // response ends the fill, so any memory latency works.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d    = {miss_address[ADDR_W-1:4], 4'h0};
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (req_pending) begin
          req_cnt_d = req_cnt_q + 4'd1;
        end
        if (memory_data_valid) begin
          rsp_cnt_d = rsp_cnt_q + 3'd1;
          if (rsp_cnt_q == RSP_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is raised combinationally in the miss cycle; masking with rst_n keeps
  // every output low while reset is held.
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_offset      = rsp_cnt_q;
    unique case (state_q)
      IDLE: begin
        fsm_busy = miss_detected & rst_n;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        memory_read_en   = req_pending;
        memory_address   = req_pending ? (base_q + ADDR_W'({req_cnt_q[2:0], 1'b0})) : '0;
        write_data_array = memory_data_valid;
        write_tag_array  = memory_data_valid && (rsp_cnt_q == RSP_LAST);
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed table-driven bench for cache_fill_fsm, plus a hand-written
// sequence for asynchronous reset in the middle of a fill.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        write_tag_array;
  logic        state_dbg;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .write_tag_array   (write_tag_array),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic        dv;
    logic [22:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];
  int          n_vec;
  int          n_miss;
  int          tag_seen;
  logic        watch_tag;

  function automatic logic [22:0] pack(input logic busy, input logic ren, input logic [15:0] maddr,
                                       input logic wda, input logic [2:0] off, input logic tag);
    return {busy, ren, maddr, wda, off, tag};
  endfunction

  function automatic logic [22:0] actual();
    return {fsm_busy, memory_read_en, memory_address, write_data_array, word_offset, write_tag_array};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic miss, input logic [15:0] addr, input logic dv, input logic [22:0] exp);
    vec_t v;
    v.miss = miss;
    v.addr = addr;
    v.dv   = dv;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  // Single-cycle miss, memory answers with fixed 4-cycle latency.
  task automatic add_simple_fill(input logic [15:0] maddr, input logic [15:0] base);
    for (int c = 0; c <= 13; c++) begin
      logic dv, ren;
      dv  = (c >= 5) && (c <= 12);
      ren = (c >= 1) && (c <= 8);
      push(c == 0, (c == 0) ? maddr : 16'h0000, dv,
           pack(c <= 12, ren, ren ? base + 16'(2 * (c - 1)) : 16'h0000,
                dv, dv ? 3'(c - 5) : 3'd0, c == 12));
    end
  endtask

  // Miss held for 20 cycles: fill 1 sampled at cycle 0, fill 2 at cycle 13.
  task automatic add_held_miss();
    for (int c = 0; c <= 26; c++) begin
      int   k;
      logic miss, dv, ren;
      miss = (c < 20);
      k    = (c >= 13) ? c - 13 : c;
      dv   = (k >= 5) && (k <= 12);
      ren  = (k >= 1) && (k <= 8);
      push(miss, miss ? 16'h4327 : 16'h0000, dv,
           pack(c <= 25, ren, ren ? 16'h4320 + 16'(2 * (k - 1)) : 16'h0000,
                dv, dv ? 3'(k - 5) : 3'd0, k == 12));
    end
  endtask

  // Irregular response gaps: offset advances only on valid cycles.
  task automatic add_gappy_fill();
    int vlist[8] = '{5, 7, 8, 11, 12, 15, 16, 20};
    for (int c = 0; c <= 21; c++) begin
      int   cnt;
      logic dv, ren;
      cnt = 0;
      dv  = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (vlist[j] < c) cnt++;
        if (vlist[j] == c) dv = 1'b1;
      end
      ren = (c >= 1) && (c <= 8);
      push(c == 0, (c == 0) ? 16'h0A5C : 16'h0000, dv,
           pack(c <= 20, ren, ren ? 16'h0A50 + 16'(2 * (c - 1)) : 16'h0000,
                dv, 3'(cnt % 8), c == 20));
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got busy/ren/addr/wda/off/tag=%h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (watch_tag && write_tag_array) tag_seen++;
  end

  // ---------------- test ----------------
  initial begin
    n_vec             = 0;
    n_miss            = 0;
    tag_seen          = 0;
    watch_tag         = 1'b0;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;

    // Stray valids with no miss, then three fill scenarios.
    push(1'b0, 16'h0000, 1'b1, pack(0, 0, 16'h0000, 0, 3'd0, 0));
    push(1'b0, 16'h0000, 1'b1, pack(0, 0, 16'h0000, 0, 3'd0, 0));
    push(1'b0, 16'h0000, 1'b0, pack(0, 0, 16'h0000, 0, 3'd0, 0));
    add_simple_fill(16'h1234, 16'h1230);
    add_simple_fill(16'hFFFF, 16'hFFF0);
    add_held_miss();
    add_gappy_fill();
    foreach (tbl[i]) exp_q.push_back(tbl[i].exp);

    // Reset state, including a miss asserted while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", pack(0, 0, 16'h0000, 0, 3'd0, 0));
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    #1;
    check("reset_miss_masked", pack(0, 0, 16'h0000, 0, 3'd0, 0));
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (tbl[i]) begin
      logic [22:0] e;
      @(posedge clk);
      #1;
      miss_detected     = tbl[i].miss;
      miss_address      = tbl[i].addr;
      memory_data_valid = tbl[i].dv;
      e = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("vec%0d", i), e);
    end

    // Asynchronous reset in cycle 7 of a fill, then stray valids in IDLE.
    watch_tag = 1'b1;
    @(posedge clk);
    #1;
    miss_detected     = 1'b1;
    miss_address      = 16'h2468;
    memory_data_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      miss_address      = 16'h0000;
      memory_data_valid = (c >= 5);
    end
    @(negedge clk);
    check("pre_reset_c7", pack(1, 1, 16'h246C, 1, 3'd2, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_fill", pack(0, 0, 16'h0000, 0, 3'd0, 0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      memory_data_valid = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("idle_stray_dv%0d", i), pack(0, 0, 16'h0000, 0, 3'd0, 0));
    end
    memory_data_valid = 1'b0;
    watch_tag = 1'b0;
    n_vec++;
    if (tag_seen != 0) begin
      n_miss++;
      $display("FAIL abort_no_tag: got %0d tag pulses required 0", tag_seen);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
